// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory store buffer.
// Define STBUF_COALESCE_EN to merge stores into matching queued (non-head) entries.
package dmem_pkg;

    localparam int unsigned DmemDepth = 4;
    localparam int unsigned DmemAw    = 32;
    localparam int unsigned DmemDw    = 32;

`ifdef STBUF_COALESCE_EN
    localparam bit CoalesceEn = 1'b1;
`else
    localparam bit CoalesceEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWrWait = 2'd1,
        StRdWait = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [DmemAw-3:0] addr;
        logic [DmemDw-1:0] data;
    } stbuf_entry_t;

endpackage

// File: rtl/stbuf_fifo.sv
// Store FIFO: entry storage, head/tail pointers, occupancy and youngest-match lookup.
module stbuf_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DmemDepth,
    parameter int unsigned AW    = DmemAw,
    parameter int unsigned DW    = DmemDw,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [AW-3:0]   push_addr,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    input  logic            upd,
    input  logic [PtrW-1:0] upd_idx,
    input  logic [DW-1:0]   upd_data,
    input  logic [AW-3:0]   lookup_addr,
    output logic [PtrW:0]   count,
    output logic [AW-3:0]   head_addr,
    output logic [DW-1:0]   head_data,
    output logic            fwd_hit,
    output logic [DW-1:0]   fwd_data,
    output logic            co_hit,
    output logic [PtrW-1:0] co_idx
);

    stbuf_entry_t    entries_q [DEPTH];
    logic [PtrW-1:0] head_q, tail_q;
    logic [PtrW:0]   count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PtrW'(1);
            end
            if (push) begin
                entries_q[tail_q] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                tail_q            <= tail_q + PtrW'(1);
            end
            if (upd) begin
                entries_q[upd_idx].data <= upd_data;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count     = count_q;
    assign head_addr = entries_q[head_q].addr;
    assign head_data = entries_q[head_q].data;

    // Walk oldest to youngest so the last match wins; offset 0 is the head and is
    // never a coalesce target because it is in flight or about to launch.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx      = head_q;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        co_hit   = 1'b0;
        co_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if (entries_q[idx].valid && (entries_q[idx].addr == lookup_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries_q[idx].data;
                if (i != 0) begin
                    co_hit = 1'b1;
                    co_idx = idx;
                end
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the MEM stage and a req/ack data memory.
// Define STBUF_COALESCE_EN to merge stores into matching queued (non-head) entries.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DmemDepth,
    parameter int unsigned AW    = DmemAw,
    parameter int unsigned DW    = DmemDw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_we_i,
    input  logic          cpu_re_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_rvalid_o,
    output logic          cpu_stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    logic [AW-3:0]   cpu_word;
    logic            unused_addr_lsb;
    logic [PtrW:0]   fifo_count;
    logic [AW-3:0]   head_addr;
    logic [DW-1:0]   head_data;
    logic            fwd_hit, co_hit;
    logic [DW-1:0]   fwd_data;
    logic [PtrW-1:0] co_idx;

    logic is_store, is_load, full, coalesce, push, mem_ack, rd_ack, wr_ack, load_miss;

    assign cpu_word        = cpu_addr_i[AW-1:2];
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    // A simultaneous store and load is treated as a store only.
    assign is_store  = cpu_we_i;
    assign is_load   = cpu_re_i & ~cpu_we_i;
    assign full      = (fifo_count == (PtrW+1)'(DEPTH));
    assign coalesce  = CoalesceEn & is_store & co_hit;
    assign push      = is_store & ~full & ~coalesce;
    assign mem_ack   = mem_ack_i & req_q;
    assign rd_ack    = mem_ack & ~we_q;
    assign wr_ack    = mem_ack & we_q;
    assign load_miss = is_load & ~fwd_hit;

    stbuf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (cpu_word),
        .push_data   (cpu_wdata_i),
        .pop         (wr_ack),
        .upd         (coalesce),
        .upd_idx     (co_idx),
        .upd_data    (cpu_wdata_i),
        .lookup_addr (cpu_word),
        .count       (fifo_count),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .co_hit      (co_hit),
        .co_idx      (co_idx)
    );

    always_comb begin
        cpu_rdata_o  = '0;
        cpu_rvalid_o = 1'b0;
        cpu_stall_o  = 1'b0;
        if (is_store) begin
            cpu_stall_o = full & ~coalesce;
        end else if (is_load) begin
            if (fwd_hit) begin
                cpu_rvalid_o = 1'b1;
                cpu_rdata_o  = fwd_data;
            end else if (rd_ack) begin
                cpu_rvalid_o = 1'b1;
                cpu_rdata_o  = mem_rdata_i;
            end else begin
                cpu_stall_o = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (load_miss) begin
                    state_d = StRdWait;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = {cpu_word, 2'b00};
                end else if (fifo_count != '0) begin
                    state_d = StWrWait;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {head_addr, 2'b00};
                    wdata_d = head_data;
                end else if (push) begin
                    // Empty buffer: launch the store being pushed this cycle directly.
                    state_d = StWrWait;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {cpu_word, 2'b00};
                    wdata_d = cpu_wdata_i;
                end
            end
            StWrWait: begin
                if (wr_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            StRdWait: begin
                if (rd_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits directly downstream of the pipeline's MEM stage.
- Consumes the MEM-stage store/load requests (address from ALU result, store data from rD2, write enable) and returns load data for the WB-select path.
- Decouples the single-cycle CPU from a slower data memory that uses a req/ack handshake: stores are posted into a FIFO and drained in order; loads are forwarded from the buffer or fetched from memory.

Parameters:
- DEPTH, 4, store-FIFO entries; power of two, at least 2.
- AW, 32, address width in bits.
- DW, 32, data width in bits; full-word accesses only.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cpu_we_i  in  1  MEM-stage store request.
- cpu_re_i  in  1  MEM-stage load request.
- cpu_addr_i  in  AW  byte address; bits [1:0] ignored.
- cpu_wdata_i  in  DW  store data.
- cpu_rdata_o  out  DW  load data, valid when cpu_rvalid_o=1.
- cpu_rvalid_o  out  1  load data valid this cycle.
- cpu_stall_o  out  1  CPU must hold the pipeline and its request this cycle.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  AW  memory word address (byte address with [1:0]=0).
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data, valid with mem_ack_i on a read.
- mem_ack_i  in  1  request completed this cycle.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: FIFO empty (head=tail=count=0); FSM=IDLE; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; cpu_rvalid_o=0, cpu_stall_o=0, cpu_rdata_o=0.
- Reset mid-transaction: all entries discarded; mem_req_o low on the cycle after rst is sampled; any in-flight ack is ignored.
- Request priority: one CPU op per cycle. If cpu_we_i and cpu_re_i are both high, the store wins and the load is ignored.
- Address match: compares addr[AW-1:2] only.
- Store accept: if count<DEPTH, the entry is written at tail in the same cycle and cpu_stall_o=0.
- Store when full: if count==DEPTH, cpu_stall_o=1, even if mem_ack_i frees an entry that cycle (full is decided from the registered count). The store is accepted on the first cycle with count<DEPTH.
- Load hit: scan valid entries for a matching address and forward the youngest match combinationally: cpu_rvalid_o=1, cpu_stall_o=0, zero latency. This includes the head entry while it is in flight.
- Load miss: cpu_stall_o=1 until the read ack. In the ack cycle: cpu_rdata_o=mem_rdata_i, cpu_rvalid_o=1, cpu_stall_o=0.
- FSM states: IDLE, WR_WAIT, RD_WAIT.
  - IDLE → RD_WAIT on a load miss. The load has priority over draining.
  - IDLE → WR_WAIT when count>0 and there is no load miss; head is presented with mem_we_o=1.
  - WR_WAIT → IDLE on mem_ack_i; head is popped and count decrements.
  - A load miss arriving during WR_WAIT stays stalled until the write ack, then enters RD_WAIT.
  - RD_WAIT → IDLE on mem_ack_i.
- Memory handshake: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and held stable from assertion until the cycle mem_ack_i=1. mem_req_o drops the next cycle, so each request gets at least one idle cycle. mem_ack_i is ignored while mem_req_o=0.
- Pointers: head/tail are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop (count<DEPTH): count is unchanged and both pointers advance.
- Ordering: stores reach memory strictly in program order.

Optional Feature:
- Macro: STBUF_COALESCE_EN.
- Defined: a store whose address matches a valid entry that is not the in-flight head overwrites that entry's data in place. No allocation and no stall occur, even when the FIFO is full.
- Undefined: every accepted store allocates a new entry.

Decomposition:
- Shared package dmem_pkg holds:
  - FSM state enum (IDLE/WR_WAIT/RD_WAIT);
  - store-entry struct (valid, word address, data);
  - DEPTH/AW/DW defaults.
- One natural sub-module, stbuf_fifo: storage, pointers, count, youngest-match forward lookup. The parent dmem_store_buffer holds the FSM and both handshakes.

Test Plan:
- Post-reset store 0x100←0xA5A5A5A5 with mem_ack_i held low: no stall; mem_req_o=1, mem_we_o=1, mem_addr_o=0x100 next cycle; held until ack; count→0 after ack.
- Five stores with ack low (DEPTH=4): first four accepted; fifth stalls. Ack on the head releases the stall the following cycle; memory sees the writes in order.
- Stores 0x200←1, then 0x200←2, then load 0x200: rdata=2 and rvalid=1 in the same cycle, no memory read issued.
- Load miss 0x300 while a write is in flight: stall through the write ack; read issued; ack with mem_rdata_i=0xDEADBEEF gives rdata=0xDEADBEEF, rvalid=1, stall=0 that cycle.
- Assert rst during WR_WAIT with 3 entries: mem_req_o=0 and count=0 the next cycle; a later ack has no effect.
- With STBUF_COALESCE_EN, full FIFO, store to the address of a non-head entry: no stall, data updated, count still 4.
